vend_ctrl: RTL and testbench

//   Sequencing controller for the coin-operated vending datapath.
//   - Accumulates coin credit and starts a vend when credit >= PRICE.
//   - Drives a req/ack handshake to the item dispenser, with a timeout.
//   - Returns change, or a refund on cancel or dispenser fault, as a

---
 rtl/vend_ctrl.sv | 132 +++++++++++++
 tb/tb_vend_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending sequencing controller: coin credit accumulation, dispenser
// req/ack handshake with timeout, and paced half-unit change/refund output.
module vend_ctrl #(
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned PRICE       = 5,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned CHANGE_GAP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                vend_done,
  output logic                disp_err,
  output logic                change_half,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GAP_W = (CHANGE_GAP > 0) ? $clog2(CHANGE_GAP + 1) : 1;

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]     TO_ONE     = TO_W'(1);
  localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(CHANGE_GAP);
  localparam logic [GAP_W-1:0]    GAP_ONE    = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_VEND   = 3'b010,
    S_CHANGE = 3'b100
  } state_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [TO_W-1:0]     to_cnt, to_nx;
  logic [GAP_W-1:0]    gap_cnt, gap_nx;
  logic                done_nx, err_nx, half_nx, rej_nx;
  logic [CREDIT_W:0]   sum;

  // One extra bit so an overflowing coin is detectable without wrapping.
  assign sum = {1'b0, credit} + (CREDIT_W + 1)'(coin);

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    to_nx     = to_cnt;
    gap_nx    = gap_cnt;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    half_nx   = 1'b0;
    rej_nx    = 1'b0;
    unique case (state)
      S_IDLE: begin
        to_nx  = '0;
        gap_nx = '0;
        if (credit >= PRICE_C) begin
          state_nx = S_VEND;
          rej_nx   = |coin;
        end else if (cancel) begin
          rej_nx = |coin;
          if (credit != '0) state_nx = S_CHANGE;
        end else if (coin != '0) begin
          if (!sum[CREDIT_W]) credit_nx = sum[CREDIT_W-1:0];
          else                rej_nx    = 1'b1;
        end
      end
      S_VEND: begin
        rej_nx = |coin;
        if (disp_ack) begin
          credit_nx = credit - PRICE_C;
          done_nx   = 1'b1;
          gap_nx    = '0;
          state_nx  = (credit != PRICE_C) ? S_CHANGE : S_IDLE;
        end else if (to_cnt == TO_LAST) begin
          // Counter holds 0..ACK_TIMEOUT-1, so disp_req spans exactly ACK_TIMEOUT cycles.
          err_nx   = 1'b1;
          gap_nx   = '0;
          state_nx = S_CHANGE;
        end else begin
          to_nx = to_cnt + TO_ONE;
        end
      end
      S_CHANGE: begin
        rej_nx = |coin;
        if (credit == '0) begin
          state_nx = S_IDLE;
        end else if (gap_cnt == '0) begin
          half_nx   = 1'b1;
          credit_nx = credit - ONE_C;
          gap_nx    = GAP_RELOAD;
          if (credit == ONE_C) state_nx = S_IDLE;
        end else begin
          gap_nx = gap_cnt - GAP_ONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      credit      <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      vend_done   <= 1'b0;
      disp_err    <= 1'b0;
      change_half <= 1'b0;
      coin_rej    <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      to_cnt      <= to_nx;
      gap_cnt     <= gap_nx;
      vend_done   <= done_nx;
      disp_err    <= err_nx;
      change_half <= half_nx;
      coin_rej    <= rej_nx;
    end
  end

  // Decoded from the state register so both drop the instant rst asserts.
  assign disp_req = (state == S_VEND);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus queues expected output pulses,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req, vend_done, disp_err, change_half, coin_rej, busy;
  logic [3:0] credit;

  logic [1:0] coin2 = 2'd0;
  logic       cancel2 = 1'b0;
  logic       ack2 = 1'b0;
  logic       disp_req2, vend_done2, disp_err2, change_half2, coin_rej2, busy2;
  logic [3:0] credit2;

  always #5 clk = ~clk;

  vend_ctrl #(.CREDIT_W(4), .PRICE(5), .ACK_TIMEOUT(8), .CHANGE_GAP(1)) dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .disp_ack(disp_ack),
    .disp_req(disp_req), .vend_done(vend_done), .disp_err(disp_err),
    .change_half(change_half), .coin_rej(coin_rej), .credit(credit), .busy(busy)
  );

  vend_ctrl #(.CREDIT_W(4), .PRICE(15), .ACK_TIMEOUT(8), .CHANGE_GAP(1)) dut2 (
    .clk(clk), .rst(rst), .coin(coin2), .cancel(cancel2), .disp_ack(ack2),
    .disp_req(disp_req2), .vend_done(vend_done2), .disp_err(disp_err2),
    .change_half(change_half2), .coin_rej(coin_rej2), .credit(credit2), .busy(busy2)
  );

  typedef enum int {EV_DONE = 1, EV_ERR = 2, EV_HALF = 3, EV_REJ = 4} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] credit;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  prev_half = 0;
  bit  have_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [3:0] c);
    ev_t e;
    e.kind   = k;
    e.credit = c;
    exp_q.push_back(e);
  endtask

  task automatic score(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d with credit %0d expected none (t=%0t)",
               k, credit, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_credit", credit, e.credit);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (coin_rej)  score(EV_REJ);
      if (vend_done) score(EV_DONE);
      if (disp_err)  score(EV_ERR);
      if (change_half) begin
        score(EV_HALF);
        if (have_prev) chk("change_spacing", cyc - prev_half, 2);
        have_prev = 1'b1;
        prev_half = cyc;
      end
      if (!busy) have_prev = 1'b0;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin = v;
    tick();
    coin = 2'd0;
  endtask

  task automatic put_coin2(input logic [1:0] v);
    coin2 = v;
    tick();
    coin2 = 2'd0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!disp_req && n < 40) begin
      tick();
      n++;
    end
    chk("wait_disp_req", disp_req, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic ack_after(input int d);
    repeat (d) tick();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int guard;
    repeat (2) tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {disp_req, vend_done, disp_err, change_half, coin_rej}, 0);
    rst = 1'b0;
    tick();

    // T1 exact price
    put_coin(2'd2); chk("t1_credit2", credit, 2);
    put_coin(2'd2); chk("t1_credit4", credit, 4);
    put_coin(2'd1); chk("t1_credit5", credit, 5);
    chk("t1_idle_before_vend", busy, 0);
    wait_req();
    chk("t1_credit_in_vend", credit, 5);
    expect_ev(EV_DONE, 4'd0);
    ack_after(3);
    wait_idle();
    chk("t1_credit_end", credit, 0);
    drain();

    // T2 overpay
    put_coin(2'd2); put_coin(2'd2); put_coin(2'd2);
    chk("t2_credit6", credit, 6);
    wait_req();
    expect_ev(EV_DONE, 4'd1);
    expect_ev(EV_HALF, 4'd0);
    ack_after(1);
    wait_idle();
    chk("t2_credit_end", credit, 0);
    drain();

    // T3 cancel refund
    put_coin(2'd3);
    chk("t3_credit3", credit, 3);
    expect_ev(EV_HALF, 4'd2);
    expect_ev(EV_HALF, 4'd1);
    expect_ev(EV_HALF, 4'd0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t3_busy", busy, 1);
    wait_idle();
    chk("t3_credit_end", credit, 0);
    drain();

    // T4 dispenser fault
    put_coin(2'd2); put_coin(2'd2); put_coin(2'd1);
    expect_ev(EV_ERR, 4'd5);
    for (int i = 4; i >= 0; i--) expect_ev(EV_HALF, 4'(i));
    wait_req();
    cnt = 0;
    guard = 0;
    while (disp_req && guard < 30) begin
      cnt++;
      tick();
      guard++;
    end
    chk("t4_req_high_cycles", cnt, 8);
    wait_idle();
    chk("t4_credit_end", credit, 0);
    drain();

    // T5 coin during VEND
    put_coin(2'd2); put_coin(2'd2); put_coin(2'd1);
    wait_req();
    expect_ev(EV_REJ, 4'd5);
    put_coin(2'd1);
    chk("t5_credit_vend", credit, 5);
    expect_ev(EV_DONE, 4'd0);
    ack_after(1);
    wait_idle();
    drain();

    // T5 coin together with cancel at zero credit
    expect_ev(EV_REJ, 4'd0);
    coin = 2'd2;
    cancel = 1'b1;
    tick();
    coin = 2'd0;
    cancel = 1'b0;
    chk("t5_cancel_zero_busy", busy, 0);
    chk("t5_cancel_zero_credit", credit, 0);
    drain();

    // T5 overflow reject at PRICE=15
    repeat (7) put_coin2(2'd2);
    chk("t5_p15_credit14", credit2, 14);
    put_coin2(2'd2);
    chk("t5_p15_rej", coin_rej2, 1);
    chk("t5_p15_credit_hold", credit2, 14);
    put_coin2(2'd1);
    chk("t5_p15_credit15", credit2, 15);
    chk("t5_p15_no_rej", coin_rej2, 0);

    // T6 reset mid-CHANGE
    put_coin(2'd3);
    expect_ev(EV_HALF, 4'd2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    tick();
    chk("t6_busy_mid", busy, 1);
    chk("t6_credit_mid", credit, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_outputs", {disp_req, vend_done, disp_err, change_half, coin_rej}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_after_busy", busy, 0);
    chk("t6_after_credit", credit, 0);
    drain();

    // Reset while requesting drops disp_req without waiting for a clock
    put_coin(2'd2); put_coin(2'd2); put_coin(2'd1);
    wait_req();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_disp_req", disp_req, 0);
    tick();
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
